bool_func_sweeper: RTL

//  Parametrised, self-sequencing evaluator for an N-input Boolean function held in a programmable truth-table LUT.
//  On start, sweeps every input vector 0..2^N-1, streams (vector, F) over a valid/ready port and counts minterms.

---
 rtl/bool_sweep_pkg.sv | 20 ++
 rtl/bool_lut_eval.sv | 30 +++
 rtl/bool_func_sweeper.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/bool_sweep_pkg.sv
// Shared definitions for the Boolean function sweeper: FSM state encoding,
// MISR constants and the MISR step helper used when SWEEP_SIG_EN is defined.
package bool_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [15:0] SIG_POLY = 16'h1021;
  localparam logic [15:0] SIG_SEED = 16'hFFFF;

  // One MISR step: shift left, fold back the polynomial on MSB carry-out,
  // then inject the new data bit into the LSB.
  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic d);
    return {s[14:0], 1'b0} ^ (s[15] ? SIG_POLY : 16'h0000) ^ {15'b0, d};
  endfunction

endpackage

// File: rtl/bool_lut_eval.sv
// Truth-table storage for the sweeper: a 2^N_IN-bit LUT register with a load
// enable and a purely combinational lookup of the addressed entry.
module bool_lut_eval
  import bool_sweep_pkg::*;
#(
  parameter int                      N_IN     = 4,
  parameter logic [(1<<N_IN)-1:0]    LUT_INIT = 16'hF830
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [(1<<N_IN)-1:0]    lut_in,
  input  logic [N_IN-1:0]         vec,
  output logic                    f
);

  logic [(1<<N_IN)-1:0] lut_r;

  // LUT register: reverts to the build-time table on reset, loads on request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lut_r <= LUT_INIT;
    end else if (load) begin
      lut_r <= lut_in;
    end
  end

  assign f = lut_r[vec];

endmodule

// File: rtl/bool_func_sweeper.sv
// Self-sequencing evaluator: on start, streams (vector, F) for every input
// vector 0..2^N_IN-1 over a valid/ready port and counts the minterms seen.
// Optional feature macro: SWEEP_SIG_EN adds a 16-bit MISR signature output.
module bool_func_sweeper
  import bool_sweep_pkg::*;
#(
  parameter int                      N_IN     = 4,
  parameter logic [(1<<N_IN)-1:0]    LUT_INIT = 16'hF830
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_we,
  input  logic [(1<<N_IN)-1:0]    cfg_lut,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_IN-1:0]         out_vec,
  output logic                    out_f,
  output logic [N_IN:0]           ones_count
`ifdef SWEEP_SIG_EN
  ,
  output logic [15:0]             sig
`endif
);

  localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

  state_t            state_r;
  state_t            state_s;
  logic [N_IN-1:0]   vec_r;
  logic              valid_r;
  logic [N_IN:0]     ones_r;
  logic              busy_r;
  logic              done_r;
  logic              f_s;
  logic              start_s;
  logic              load_s;
  logic              xfer_s;
  logic              last_s;

  // Configuration and start are only honoured while idle; the LUT is frozen otherwise.
  assign start_s = (state_r == ST_IDLE) & start;
  assign load_s  = (state_r == ST_IDLE) & cfg_we;
  assign xfer_s  = (state_r == ST_RUN) & valid_r & out_ready;
  assign last_s  = xfer_s & (vec_r == VEC_LAST);

  bool_lut_eval #(
    .N_IN     (N_IN),
    .LUT_INIT (LUT_INIT)
  ) u_lut (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load_s),
    .lut_in (cfg_lut),
    .vec    (vec_r),
    .f      (f_s)
  );

  // Next-state logic: IDLE -> RUN on start, RUN -> DONE on last transfer, DONE lasts one cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Status flags registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s != ST_IDLE);
      done_r <= (state_s == ST_DONE);
    end
  end

  // Vector counter, valid flag and minterm counter; all hold while the sink stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_r   <= '0;
      valid_r <= 1'b0;
      ones_r  <= '0;
    end else if (start_s) begin
      vec_r   <= '0;
      valid_r <= 1'b1;
      ones_r  <= '0;
    end else if (xfer_s) begin
      ones_r <= ones_r + {{N_IN{1'b0}}, f_s};
      if (last_s) begin
        vec_r   <= '0;
        valid_r <= 1'b0;
      end else begin
        vec_r   <= vec_r + N_IN'(1'b1);
      end
    end
  end

`ifdef SWEEP_SIG_EN
  logic [15:0] sig_r;

  // MISR over the streamed F values; seeded on start and held outside transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_r <= SIG_SEED;
    end else if (start_s) begin
      sig_r <= SIG_SEED;
    end else if (xfer_s) begin
      sig_r <= misr_step(sig_r, f_s);
    end
  end

  assign sig = sig_r;
`endif

  assign busy       = busy_r;
  assign done       = done_r;
  assign out_valid  = valid_r;
  assign out_vec    = vec_r;
  assign out_f      = f_s;
  assign ones_count = ones_r;

endmodule
